// File: rtl/bram_access_sequencer_pkg.sv
// bram_access_sequencer_pkg
// Shared definitions for the BRAM access sequencer:
//   - 3-bit state encodings (IDLE, PH_I1, PH_I2, PH_D, PH_W) and their enum
//   - PHASE_COUNT: number of RAM phases per access bundle (4)
//   - INSTR_W: width of an instruction word (fixed at 16)
//   - helpers that map a state to its phase strobes and to request acceptance
package bram_access_sequencer_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PH_I1 = 3'd1;
  localparam logic [2:0] ST_PH_I2 = 3'd2;
  localparam logic [2:0] ST_PH_D  = 3'd3;
  localparam logic [2:0] ST_PH_W  = 3'd4;

  localparam int PHASE_COUNT = 4;
  localparam int INSTR_W     = 16;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    PH_I1 = ST_PH_I1,
    PH_I2 = ST_PH_I2,
    PH_D  = ST_PH_D,
    PH_W  = ST_PH_W
  } state_t;

  // Strobe vector {i1re, i2re, dre, gwe} for a state; one-hot in a phase
  // state and all-zero in IDLE.
  function automatic logic [3:0] phase_strobes(state_t s);
    logic [3:0] stb;
    stb = 4'b0000;
    case (s)
      PH_I1:   stb = 4'b1000;
      PH_I2:   stb = 4'b0100;
      PH_D:    stb = 4'b0010;
      PH_W:    stb = 4'b0001;
      default: stb = 4'b0000;
    endcase
    return stb;
  endfunction

  // A new bundle can be taken while idle or during the last phase, which
  // is what allows back-to-back bundles without an IDLE gap.
  function automatic logic accepts_request(state_t s);
    return (s == IDLE) || (s == PH_W);
  endfunction

endpackage

// File: rtl/bram_access_sequencer_if.sv
// bram_access_sequencer_if / bram_ram_if
// bram_access_sequencer_if: request/response bundle between the processor
//   stages (master) and the sequencer (slave).
//     req_valid/req_ready handshake, req_i1addr, req_i2addr, req_daddr,
//     req_din, req_dwe; response rsp_valid pulse with rsp_i1, rsp_i2, rsp_dout.
// bram_ram_if: the RAM's time-multiplexed port, driven by the sequencer
//   (master) toward the RAM (slave).
//     strobes i1re, i2re, dre, gwe; addresses i1addr, i2addr, daddr;
//     write data din with enable dwe; RAM outputs i1out, i2out, dout.
interface bram_access_sequencer_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic                                       req_valid;
  logic                                       req_ready;
  logic [ADDR_W-1:0]                          req_i1addr;
  logic [ADDR_W-1:0]                          req_i2addr;
  logic [ADDR_W-1:0]                          req_daddr;
  logic [DATA_W-1:0]                          req_din;
  logic                                       req_dwe;
  logic                                       rsp_valid;
  logic [bram_access_sequencer_pkg::INSTR_W-1:0] rsp_i1;
  logic [bram_access_sequencer_pkg::INSTR_W-1:0] rsp_i2;
  logic [DATA_W-1:0]                          rsp_dout;

  modport master (
    output req_valid, req_i1addr, req_i2addr, req_daddr, req_din, req_dwe,
    input  req_ready, rsp_valid, rsp_i1, rsp_i2, rsp_dout
  );

  modport slave (
    input  req_valid, req_i1addr, req_i2addr, req_daddr, req_din, req_dwe,
    output req_ready, rsp_valid, rsp_i1, rsp_i2, rsp_dout
  );
endinterface

interface bram_ram_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic                                       i1re;
  logic                                       i2re;
  logic                                       dre;
  logic                                       gwe;
  logic [ADDR_W-1:0]                          i1addr;
  logic [ADDR_W-1:0]                          i2addr;
  logic [ADDR_W-1:0]                          daddr;
  logic [DATA_W-1:0]                          din;
  logic                                       dwe;
  logic [bram_access_sequencer_pkg::INSTR_W-1:0] i1out;
  logic [bram_access_sequencer_pkg::INSTR_W-1:0] i2out;
  logic [DATA_W-1:0]                          dout;

  modport master (
    output i1re, i2re, dre, gwe, i1addr, i2addr, daddr, din, dwe,
    input  i1out, i2out, dout
  );

  modport slave (
    input  i1re, i2re, dre, gwe, i1addr, i2addr, daddr, din, dwe,
    output i1out, i2out, dout
  );
endinterface

// File: rtl/bram_access_sequencer_nbit_reg.sv
// Nbit_reg
// Generic N-bit register with global and local write enables.
//   clk, rst : clock and asynchronous active-high reset (clears to 0)
//   gwe, we  : register loads d only when both are high
//   d, q     : data in / registered data out
module Nbit_reg #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         gwe,
  input  logic         we,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (gwe && we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/bram_access_sequencer.sv
// bram_access_sequencer
// Drives the block RAM's time-multiplexed port for one access bundle at a
// time: PH_I1 (i1re), PH_I2 (i2re), PH_D (dre, optional dwe), PH_W (gwe),
// then pulses rsp_valid with both instruction words and the data word.
//   idclk : fast clock, 4x the processor rate
//   rst   : asynchronous active-high reset
//   bus   : request/response bundle (slave side)
//   ram   : RAM port (master side)
module bram_access_sequencer
  import bram_access_sequencer_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input logic                   idclk,
  input logic                   rst,
  bram_access_sequencer_if.slave bus,
  bram_ram_if.master            ram
);

  localparam int HOLD_W = 3 * ADDR_W + DATA_W + 1;
  localparam int RSP_W  = 2 * INSTR_W + DATA_W;

  state_t            state;
  state_t            next_state;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic [3:0]        strobes_q;
  logic              dwe_q;
  logic              accept;
  logic              capture_rsp;
  logic [HOLD_W-1:0] hold_d;
  logic [HOLD_W-1:0] hold_q;
  logic [RSP_W-1:0]  rsp_d;
  logic [RSP_W-1:0]  rsp_q;
  logic              hold_dwe;

  assign accept      = bus.req_valid & req_ready_q;
  assign capture_rsp = (state == PH_W);

  // The whole request is latched once at acceptance so the RAM address and
  // write-data lines stay stable across all four phases.
  assign hold_d = {bus.req_i1addr, bus.req_i2addr, bus.req_daddr,
                   bus.req_din, bus.req_dwe};

  Nbit_reg #(.N(HOLD_W)) hold_reg (
    .clk (idclk),
    .rst (rst),
    .gwe (1'b1),
    .we  (accept),
    .d   (hold_d),
    .q   (hold_q)
  );

  // RAM outputs are all valid during PH_W and are sampled at its closing
  // edge; the fields then hold until the next bundle completes.
  assign rsp_d = {ram.i1out, ram.i2out, ram.dout};

  Nbit_reg #(.N(RSP_W)) rsp_reg (
    .clk (idclk),
    .rst (rst),
    .gwe (1'b1),
    .we  (capture_rsp),
    .d   (rsp_d),
    .q   (rsp_q)
  );

  assign hold_dwe = hold_q[0];

  // Phase ordering is fixed; only IDLE and PH_W look at the request.
  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE:    next_state = accept ? PH_I1 : IDLE;
      PH_I1:   next_state = PH_I2;
      PH_I2:   next_state = PH_D;
      PH_D:    next_state = PH_W;
      PH_W:    next_state = accept ? PH_I1 : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered from the next state so each strobe is high for
  // exactly the cycle its phase occupies. dwe rides with PH_D only, so the
  // RAM sees a single write per bundle. rsp_valid follows PH_W by one cycle,
  // so a reset during PH_W loses the response.
  always_ff @(posedge idclk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      req_ready_q <= 1'b1;
      strobes_q   <= 4'b0000;
      dwe_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state       <= next_state;
      req_ready_q <= accepts_request(next_state);
      strobes_q   <= phase_strobes(next_state);
      dwe_q       <= (next_state == PH_D) && hold_dwe;
      rsp_valid_q <= (state == PH_W);
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_i1    = rsp_q[RSP_W-1 -: INSTR_W];
  assign bus.rsp_i2    = rsp_q[RSP_W-INSTR_W-1 -: INSTR_W];
  assign bus.rsp_dout  = rsp_q[DATA_W-1:0];

  assign ram.i1re   = strobes_q[3];
  assign ram.i2re   = strobes_q[2];
  assign ram.dre    = strobes_q[1];
  assign ram.gwe    = strobes_q[0];
  assign ram.dwe    = dwe_q;
  assign ram.i1addr = hold_q[HOLD_W-1 -: ADDR_W];
  assign ram.i2addr = hold_q[HOLD_W-ADDR_W-1 -: ADDR_W];
  assign ram.daddr  = hold_q[DATA_W+ADDR_W:DATA_W+1];
  assign ram.din    = hold_q[DATA_W:1];

endmodule

// File: tb/tb_bram_access_sequencer.sv
// tb_bram_access_sequencer
// Scoreboarded bench for bram_access_sequencer with a behavioural RAM that
// registers its outputs on the strobed phase edges. Stimulus pushes the
// hand-computed response (and the cycle it must appear in) into a queue;
// a monitor pops and compares whenever rsp_valid is seen.
module tb_bram_access_sequencer;
  import bram_access_sequencer_pkg::*;

  typedef struct {
    logic [15:0] i1;
    logic [15:0] i2;
    logic [15:0] dout;
    int          cyc;
  } exp_t;

  logic        idclk;
  logic        rst;
  int          cyc;
  int          checkCount;
  int          passCount;
  exp_t        expQ[$];

  logic [15:0] mem [0:65535];
  logic        loadEn;
  logic [15:0] loadAddr;
  logic [15:0] loadData;
  logic [3:0]  stb;

  bram_access_sequencer_if #(.ADDR_W(16), .DATA_W(16)) bus ();
  bram_ram_if              #(.ADDR_W(16), .DATA_W(16)) ramIf ();

  bram_access_sequencer #(.ADDR_W(16), .DATA_W(16)) dut (
    .idclk (idclk),
    .rst   (rst),
    .bus   (bus),
    .ram   (ramIf)
  );

  initial idclk = 1'b0;
  always #5 idclk = ~idclk;

  initial cyc = 0;
  always @(posedge idclk) cyc <= cyc + 1;

  assign stb = {ramIf.i1re, ramIf.i2re, ramIf.dre, ramIf.gwe};

  // RAM model: each output registers on its own strobe edge; the data
  // read returns the pre-write contents on a read-modify-write.
  always @(posedge idclk) begin
    if (loadEn) mem[loadAddr] <= loadData;
    if (ramIf.i1re) ramIf.i1out <= mem[ramIf.i1addr];
    if (ramIf.i2re) ramIf.i2out <= mem[ramIf.i2addr];
    if (ramIf.dre) begin
      ramIf.dout <= mem[ramIf.daddr];
      if (ramIf.dwe) mem[ramIf.daddr] <= ramIf.din;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Scoreboard monitor
  always @(negedge idclk) begin
    if (!rst) begin
      if ((|stb) || ramIf.dwe)
        checkOutput("strobe_onehot",
                    32'(($countones(stb) <= 1) && (!ramIf.dwe || ramIf.dre)), 32'd1);
      if (bus.rsp_valid) begin
        checkOutput("rsp_expected_pending", 32'(expQ.size() > 0), 32'd1);
        if (expQ.size() > 0) begin
          exp_t e;
          e = expQ.pop_front();
          checkOutput("rsp_cycle", 32'(cyc), 32'(e.cyc));
          checkOutput("rsp_i1", 32'(bus.rsp_i1), 32'(e.i1));
          checkOutput("rsp_i2", 32'(bus.rsp_i2), 32'(e.i2));
          checkOutput("rsp_dout", 32'(bus.rsp_dout), 32'(e.dout));
        end
      end
    end
  end

  task automatic loadWord(input logic [15:0] a, input logic [15:0] d);
    loadEn   = 1'b1;
    loadAddr = a;
    loadData = d;
    @(negedge idclk);
    loadEn   = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge just after the accept edge
  // (the PH_I1 cycle). req_valid stays high until accepted.
  task automatic applyStimulus(input logic [15:0] i1a, input logic [15:0] i2a,
                               input logic [15:0] da, input logic [15:0] dinV,
                               input logic dweV, input bit expectRsp,
                               input logic [15:0] eI1, input logic [15:0] eI2,
                               input logic [15:0] eDout, output int accCyc);
    bit ok;
    int waited;
    exp_t e;
    ok = 1'b0;
    waited = 0;
    bus.req_valid  = 1'b1;
    bus.req_i1addr = i1a;
    bus.req_i2addr = i2a;
    bus.req_daddr  = da;
    bus.req_din    = dinV;
    bus.req_dwe    = dweV;
    while (!ok && waited < 20) begin
      ok = bus.req_ready;
      @(negedge idclk);
      waited++;
    end
    bus.req_valid = 1'b0;
    accCyc = cyc;
    if (!ok) begin
      checkOutput("accept_timeout", 32'(waited), 32'd0);
    end else if (expectRsp) begin
      e.i1 = eI1;
      e.i2 = eI2;
      e.dout = eDout;
      e.cyc = accCyc + PHASE_COUNT;
      expQ.push_back(e);
    end
  endtask

  // Walks PH_I1..PH_W checking strobe order, dwe placement and address hold.
  task automatic traceStrobes(input bit isWrite, input logic [15:0] i1a);
    logic [3:0] expStb;
    for (int k = 0; k < 4; k++) begin
      expStb = 4'b1000 >> k;
      checkOutput("trace_strobes", 32'(stb), 32'(expStb));
      checkOutput("trace_dwe", 32'(ramIf.dwe), 32'(isWrite && (k == 2)));
      checkOutput("trace_i1addr", 32'(ramIf.i1addr), 32'(i1a));
      @(negedge idclk);
    end
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) @(negedge idclk);
  endtask

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int a0, a1, a2;
    checkCount = 0;
    passCount  = 0;
    rst = 1'b1;
    loadEn = 1'b0;
    loadAddr = '0;
    loadData = '0;
    bus.req_valid = 1'b0;
    bus.req_i1addr = '0;
    bus.req_i2addr = '0;
    bus.req_daddr = '0;
    bus.req_din = '0;
    bus.req_dwe = 1'b0;
    @(negedge idclk);
    loadWord(16'h2008, 16'hA1B2);
    loadWord(16'h2009, 16'hC3D4);
    loadWord(16'h0003, 16'h0055);
    loadWord(16'h0005, 16'h5555);
    loadWord(16'h0007, 16'h0707);
    loadWord(16'h0010, 16'h1111);
    loadWord(16'h0011, 16'h2222);

    // Reset state
    checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("rst_strobes", 32'(stb), 32'd0);
    checkOutput("rst_dwe", 32'(ramIf.dwe), 32'd0);
    checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("rst_i1addr", 32'(ramIf.i1addr), 32'd0);
    checkOutput("rst_daddr", 32'(ramIf.daddr), 32'd0);
    checkOutput("rst_din", 32'(ramIf.din), 32'd0);
    checkOutput("rst_rsp_i1", 32'(bus.rsp_i1), 32'd0);
    checkOutput("rst_rsp_dout", 32'(bus.rsp_dout), 32'd0);
    rst = 1'b0;
    idleCycles(2);

    // Single read with phase trace
    $display("[TB] single read");
    applyStimulus(16'h2008, 16'h2009, 16'h0003, 16'h0000, 1'b0, 1'b1,
                  16'hA1B2, 16'hC3D4, 16'h0055, a0);
    traceStrobes(1'b0, 16'h2008);
    idleCycles(3);

    // Write returns old value, then read back
    $display("[TB] write then read back");
    applyStimulus(16'h2008, 16'h2009, 16'h0003, 16'h1234, 1'b1, 1'b1,
                  16'hA1B2, 16'hC3D4, 16'h0055, a0);
    traceStrobes(1'b1, 16'h2008);
    idleCycles(2);
    applyStimulus(16'h0010, 16'h0011, 16'h0003, 16'h0000, 1'b0, 1'b1,
                  16'h1111, 16'h2222, 16'h1234, a0);
    idleCycles(6);

    // Back-to-back bundles
    $display("[TB] back-to-back");
    applyStimulus(16'h2008, 16'h2009, 16'h0003, 16'h0000, 1'b0, 1'b1,
                  16'hA1B2, 16'hC3D4, 16'h1234, a0);
    applyStimulus(16'h0010, 16'h0011, 16'h0007, 16'h0000, 1'b0, 1'b1,
                  16'h1111, 16'h2222, 16'h0707, a1);
    applyStimulus(16'h2009, 16'h0010, 16'h0005, 16'h0000, 1'b0, 1'b1,
                  16'hC3D4, 16'h1111, 16'h5555, a2);
    checkOutput("b2b_spacing_1", 32'(a1 - a0), 32'(PHASE_COUNT));
    checkOutput("b2b_spacing_2", 32'(a2 - a1), 32'(PHASE_COUNT));
    idleCycles(6);

    // Stalled upstream: request raised during PH_I2 waits for PH_W
    $display("[TB] stalled upstream");
    applyStimulus(16'h0011, 16'h2008, 16'h0007, 16'h0000, 1'b0, 1'b1,
                  16'h2222, 16'hA1B2, 16'h0707, a0);
    @(negedge idclk);
    checkOutput("stall_ready_ph_i2", 32'(bus.req_ready), 32'd0);
    applyStimulus(16'h2009, 16'h0011, 16'h0003, 16'h0000, 1'b0, 1'b1,
                  16'hC3D4, 16'h2222, 16'h1234, a1);
    checkOutput("stall_spacing", 32'(a1 - a0), 32'(PHASE_COUNT));
    idleCycles(6);

    // Reset during PH_I2 of a write to d[5]
    $display("[TB] reset mid-write");
    applyStimulus(16'h2008, 16'h2009, 16'h0005, 16'hBEEF, 1'b1, 1'b0,
                  16'h0000, 16'h0000, 16'h0000, a0);
    @(negedge idclk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_strobes", 32'(stb), 32'd0);
    checkOutput("midrst_req_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("midrst_daddr", 32'(ramIf.daddr), 32'd0);
    checkOutput("midrst_din", 32'(ramIf.din), 32'd0);
    @(negedge idclk);
    @(negedge idclk);
    rst = 1'b0;
    checkOutput("midrst_mem5", 32'(mem[16'h0005]), 32'h5555);
    idleCycles(2);
    applyStimulus(16'h0010, 16'h0011, 16'h0005, 16'h0000, 1'b0, 1'b1,
                  16'h1111, 16'h2222, 16'h5555, a0);
    idleCycles(6);

    // Reset during PH_W of a write to d[7]
    $display("[TB] reset during PH_W");
    applyStimulus(16'h2008, 16'h2009, 16'h0007, 16'h7777, 1'b1, 1'b0,
                  16'h0000, 16'h0000, 16'h0000, a0);
    idleCycles(3);
    checkOutput("phw_gwe_before_rst", 32'(ramIf.gwe), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("phw_rst_gwe", 32'(ramIf.gwe), 32'd0);
    checkOutput("phw_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge idclk);
    checkOutput("phw_no_rsp", 32'(bus.rsp_valid), 32'd0);
    @(negedge idclk);
    rst = 1'b0;
    checkOutput("phw_mem7", 32'(mem[16'h0007]), 32'h7777);
    idleCycles(2);
    applyStimulus(16'h2009, 16'h2008, 16'h0007, 16'h0000, 1'b0, 1'b1,
                  16'hC3D4, 16'hA1B2, 16'h7777, a0);
    idleCycles(8);

    checkOutput("pending_responses", 32'(expQ.size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
